// File: rtl/b_row_mac.sv
// b_row_mac: fetches VEC_LEN consecutive B rows, multiplies each by a streamed A element and
// returns the signed dot product on a valid/ready port. Optional macro: BROW_MAC_SAT_EN.
module b_row_mac #(
  parameter int unsigned ELEMENT_W = 32,
  parameter int unsigned MEM_DEPTH = 64,
  parameter int unsigned VEC_LEN   = 64,
  parameter int unsigned ACC_W     = 72
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_start,
  input  logic [$clog2(MEM_DEPTH)-1:0] i_base_row,
  output logic                         o_busy,
  output logic                         o_mem_rd,
  output logic [$clog2(MEM_DEPTH)-1:0] o_mem_row,
  input  logic                         i_mem_ack,
  input  logic [ELEMENT_W-1:0]         i_mem_data,
  input  logic                         i_a_valid,
  output logic                         o_a_ready,
  input  logic [ELEMENT_W-1:0]         i_a_data,
  output logic                         o_res_valid,
  input  logic                         i_res_ready,
`ifdef BROW_MAC_SAT_EN
  output logic                         o_sat_flag,
`endif
  output logic [ELEMENT_W-1:0]         o_res_data
);

  localparam int unsigned AW = $clog2(MEM_DEPTH);
  localparam int unsigned CW = $clog2(VEC_LEN + 1);

  typedef enum logic [2:0] {StIdle, StFetch, StWaitA, StMac, StDone} state_e;

  state_e                       r_state, w_state_next;
  logic [AW-1:0]                r_row;
  logic [CW-1:0]                r_count;
  logic signed [ACC_W-1:0]      r_acc;
  logic signed [ELEMENT_W-1:0]  r_a, r_b;
  logic [ELEMENT_W-1:0]         r_res;

  logic signed [2*ELEMENT_W-1:0] w_prod;
  logic signed [ACC_W-1:0]       w_acc_next;
  logic [AW-1:0]                 w_row_inc;
  logic                          w_last;
  logic [ELEMENT_W-1:0]          w_res;

  assign w_prod     = r_a * r_b;
  assign w_acc_next = r_acc + {{(ACC_W-2*ELEMENT_W){w_prod[2*ELEMENT_W-1]}}, w_prod};
  assign w_row_inc  = (r_row == AW'(MEM_DEPTH - 1)) ? '0 : r_row + AW'(1);
  assign w_last     = (r_count == CW'(VEC_LEN - 1));

`ifdef BROW_MAC_SAT_EN
  logic w_ovf;
  logic r_sat;

  // Fits in ELEMENT_W signed only if all bits above the result sign bit match it.
  assign w_ovf = ~((&w_acc_next[ACC_W-1:ELEMENT_W-1]) | ~(|w_acc_next[ACC_W-1:ELEMENT_W-1]));
  assign w_res = !w_ovf                ? w_acc_next[ELEMENT_W-1:0] :
                 w_acc_next[ACC_W-1]   ? {1'b1, {(ELEMENT_W-1){1'b0}}} :
                                         {1'b0, {(ELEMENT_W-1){1'b1}}};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sat <= 1'b0;
    end else if (r_state == StMac && w_last) begin
      r_sat <= w_ovf;
    end
  end

  assign o_sat_flag = r_sat & (r_state == StDone);
`else
  assign w_res = w_acc_next[ELEMENT_W-1:0];
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (i_start)     w_state_next = StFetch;
      StFetch: if (i_mem_ack)   w_state_next = StWaitA;
      StWaitA: if (i_a_valid)   w_state_next = StMac;
      StMac:                    w_state_next = w_last ? StDone : StFetch;
      StDone:  if (i_res_ready) w_state_next = StIdle;
      default:                  w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_row   <= '0;
      r_count <= '0;
      r_acc   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (i_start) begin
            r_row   <= i_base_row;
            r_acc   <= '0;
            r_count <= '0;
          end
        end
        StFetch: if (i_mem_ack) r_b <= i_mem_data;
        StWaitA: if (i_a_valid) r_a <= i_a_data;
        StMac: begin
          r_acc   <= w_acc_next;
          r_count <= r_count + CW'(1);
          r_row   <= w_row_inc;
          // Result register is loaded as DONE is entered, from the final sum.
          if (w_last) r_res <= w_res;
        end
        default: ;
      endcase
    end
  end

  assign o_busy      = (r_state != StIdle);
  assign o_mem_rd    = (r_state == StFetch);
  assign o_mem_row   = r_row;
  assign o_a_ready   = (r_state == StWaitA);
  assign o_res_valid = (r_state == StDone);
  assign o_res_data  = r_res;

endmodule

// File: tb/tb_b_row_mac.sv
// Randomized bench for b_row_mac (VEC_LEN=4) against an arithmetic dot-product model.
module tb_b_row_mac;
  localparam int unsigned EW = 32;
  localparam int unsigned MD = 64;
  localparam int unsigned VL = 4;
  localparam int unsigned AW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_row = '0;
  logic          busy, mem_rd, a_ready, res_valid;
  logic [AW-1:0] mem_row;
  logic          mem_ack = 1'b0;
  logic [EW-1:0] mem_data = '0;
  logic          a_valid = 1'b0;
  logic [EW-1:0] a_data = '0;
  logic          res_ready = 1'b0;
  logic [EW-1:0] res_data;
`ifdef BROW_MAC_SAT_EN
  logic          sat_flag;
`endif

  logic [EW-1:0] mem [MD];
  logic [EW-1:0] a_vals [VL];
  int n_checks = 0;
  int n_fail = 0;

  b_row_mac #(.ELEMENT_W(EW), .MEM_DEPTH(MD), .VEC_LEN(VL), .ACC_W(72)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_base_row(base_row), .o_busy(busy),
    .o_mem_rd(mem_rd), .o_mem_row(mem_row), .i_mem_ack(mem_ack), .i_mem_data(mem_data),
    .i_a_valid(a_valid), .o_a_ready(a_ready), .i_a_data(a_data), .o_res_valid(res_valid),
    .i_res_ready(res_ready),
`ifdef BROW_MAC_SAT_EN
    .o_sat_flag(sat_flag),
`endif
    .o_res_data(res_data)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_mem_rd"}, mem_rd, 0);
    check_eq({tag, "_mem_row"}, mem_row, 0);
    check_eq({tag, "_a_ready"}, a_ready, 0);
    check_eq({tag, "_res_valid"}, res_valid, 0);
    check_eq({tag, "_res_data"}, res_data, 0);
`ifdef BROW_MAC_SAT_EN
    check_eq({tag, "_sat_flag"}, sat_flag, 0);
`endif
  endtask

  // Exact signed dot product, then wrap or clamp to EW bits.
  function automatic logic [EW-1:0] model_res(input int base, output bit sat);
    logic signed [127:0] acc, pa, pb;
    logic signed [127:0] maxv, minv;
    maxv = 128'sd2147483647;
    minv = -128'sd2147483648;
    acc = '0;
    sat = 1'b0;
    for (int i = 0; i < VL; i++) begin
      pa = $signed(mem[(base + i) % MD]);
      pb = $signed(a_vals[i]);
      acc = acc + pa * pb;
    end
`ifdef BROW_MAC_SAT_EN
    if (acc > maxv) begin sat = 1'b1; return 32'h7FFF_FFFF; end
    if (acc < minv) begin sat = 1'b1; return 32'h8000_0000; end
`endif
    return acc[EW-1:0];
  endfunction

  // a_mode: 0 always valid, 1 random 1-in-3, 2 valid every third cycle.
  task automatic run_dot(input string tag, input int base, input int lat_min, input int lat_max,
                         input int a_mode, input int res_stall, input bit extra_start,
                         output logic [EW-1:0] got);
    logic [EW-1:0] exp;
    bit exp_sat;
    int elem, a_idx, wait_cnt, cyc;
    exp = model_res(base, exp_sat);
    @(negedge clk);
    start = 1'b1;
    base_row = AW'(base);
    @(negedge clk);
    start = 1'b0;
    base_row = AW'($urandom);
    check_eq({tag, "_busy"}, busy, 1);
    elem = 0; a_idx = 0; wait_cnt = -1; cyc = 0;
    while (!res_valid && cyc < 500) begin
      mem_ack = 1'b0;
      mem_data = $urandom;
      start = extra_start && (cyc == 3 || cyc == 9);
      if (mem_rd) begin
        if (wait_cnt < 0) wait_cnt = int'($urandom_range(lat_max, lat_min)) - 1;
        if (wait_cnt == 0) begin
          check_eq({tag, "_row"}, mem_row, (base + elem) % MD);
          mem_ack = 1'b1;
          mem_data = mem[mem_row];
          elem++;
          wait_cnt = -1;
        end else begin
          wait_cnt--;
        end
      end
      a_valid = (a_idx < VL) && (a_mode == 0 ? 1'b1 :
                                 a_mode == 1 ? ($urandom_range(2) == 0) : (cyc % 3 == 0));
      a_data = (a_idx < VL) ? a_vals[a_idx] : '0;
      if (a_valid && a_ready) a_idx++;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; mem_ack = 1'b0; a_valid = 1'b0;
    got = res_data;
    check_eq({tag, "_res_valid"}, res_valid, 1);
    check_eq({tag, "_n_reads"}, elem, VL);
    check_eq({tag, "_n_a"}, a_idx, VL);
    check_eq({tag, "_res_data"}, res_data, exp);
`ifdef BROW_MAC_SAT_EN
    check_eq({tag, "_sat_flag"}, sat_flag, exp_sat);
`endif
    for (int k = 0; k < res_stall; k++) begin
      res_ready = 1'b0;
      @(negedge clk);
      check_eq({tag, "_hold_valid"}, res_valid, 1);
      check_eq({tag, "_hold_data"}, res_data, exp);
    end
    res_ready = 1'b1;
    start = 1'b1;  // start in the DONE exit cycle must be ignored
    @(negedge clk);
    res_ready = 1'b0;
    start = 1'b0;
    check_eq({tag, "_busy_after"}, busy, 0);
    check_eq({tag, "_valid_after"}, res_valid, 0);
  endtask

  initial begin
    logic [EW-1:0] got;
    int cyc, elem;

    // Reset with random inputs.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start = 1'($urandom); base_row = AW'($urandom); mem_ack = 1'($urandom);
      mem_data = $urandom; a_valid = 1'($urandom); a_data = $urandom;
      res_ready = 1'($urandom);
      #1 check_idle("rst");
    end
    @(negedge clk);
    start = 1'b0; mem_ack = 1'b0; a_valid = 1'b0; res_ready = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle("post_rst");
    end

    // Basic dot product.
    for (int i = 0; i < VL; i++) begin
      mem[i] = 32'(i + 1);
      a_vals[i] = 32'(i + 5);
    end
    run_dot("t2", 0, 1, 1, 0, 3, 1'b0, got);
    check_eq("t2_is70", got, 70);

    // Address wrap with negative result.
    for (int i = 0; i < MD; i++) mem[i] = 32'hFFFF_FFFF;
    for (int i = 0; i < VL; i++) a_vals[i] = 32'd2;
    run_dot("t3", 62, 1, 1, 0, 0, 1'b0, got);
    check_eq("t3_is_m8", got, 32'hFFFF_FFF8);

    // Long memory latency, sparse A, stray starts.
    for (int i = 0; i < VL; i++) begin
      mem[i] = 32'(i + 1);
      a_vals[i] = 32'(i + 5);
    end
    run_dot("t4", 0, 5, 5, 2, 1, 1'b1, got);
    check_eq("t4_is70", got, 70);

    // Overflow of the EW-bit result.
    for (int i = 0; i < VL; i++) begin
      mem[10 + i] = 32'h7FFF_FFFF;
      a_vals[i] = 32'h7FFF_FFFF;
    end
    run_dot("t5", 10, 1, 2, 0, 0, 1'b0, got);
`ifdef BROW_MAC_SAT_EN
    check_eq("t5_sat", got, 32'h7FFF_FFFF);
`else
    check_eq("t5_wrap", got, 32'h0000_0004);
`endif

    // Reset during second fetch, late ack afterwards.
    for (int i = 0; i < MD; i++) mem[i] = $urandom;
    for (int i = 0; i < VL; i++) a_vals[i] = $urandom;
    @(negedge clk);
    start = 1'b1; base_row = 6'd20;
    @(negedge clk);
    start = 1'b0;
    cyc = 0; elem = 0;
    while (!(mem_rd && elem == 1) && cyc < 50) begin
      mem_ack = 1'b0;
      a_valid = 1'b1;
      a_data = a_vals[0];
      if (mem_rd) begin
        mem_ack = 1'b1;
        mem_data = mem[mem_row];
        elem++;
      end
      @(negedge clk);
      cyc++;
    end
    check_eq("t6_reached_fetch2", mem_rd, 1);
    mem_ack = 1'b0; a_valid = 1'b0;
    rst_n = 1'b0;
    #1 check_idle("t6_rst");
    @(negedge clk);
    rst_n = 1'b1;
    mem_ack = 1'b1;
    mem_data = $urandom;
    @(negedge clk);
    mem_ack = 1'b0;
    check_eq("t6_late_ack_busy", busy, 0);
    check_eq("t6_late_ack_rd", mem_rd, 0);
    run_dot("t6_fresh", 20, 1, 3, 1, 0, 1'b0, got);

    // Randomized runs.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < MD; i++) mem[i] = $urandom;
      for (int i = 0; i < VL; i++) a_vals[i] = $urandom;
      run_dot("rand", int'($urandom_range(MD - 1)), 1, int'($urandom_range(4, 1)),
              int'($urandom_range(2)), int'($urandom_range(2)), 1'($urandom), got);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
